// File: rtl/bp437_frame_seq.sv
// Frame sequencer for the 4-way interleaved (4,3,7) Berlekamp-Preparata decoder.
// Feeds received symbols to the decoder, drops its pipeline-fill outputs and
// appends DELAY zero tail symbols so every input symbol yields one corrected
// 3-bit word on the output stream, tagged with first/last markers.
//
// Optional build macro BP437SEQ_CLR_EN: adds a CLEAR state, entered after reset
// and after every frame, that pushes DELAY zero symbols so no residual decoder
// state leaks into the next frame. Without it, FLUSH returns straight to IDLE.
//
// Handshake outputs s_ready, dec_ce and dec_r are decoded in the same cycle
// from registered state and m_ready. The decoder shifts only on cycles where
// the output register can take the word it presents, so its data is never lost.

module bp437_frame_seq #(
   parameter int unsigned DELAY = 28,
   parameter int unsigned LEN_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       s_sym,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [3:0]       dec_r,
   output logic             dec_ce,
   input  logic [2:0]       dec_d,
   output logic [2:0]       m_data,
   output logic             m_valid,
   output logic             m_first,
   output logic             m_last,
   input  logic             m_ready,
   output logic             busy,
   output logic             ovf
);

   localparam int unsigned DW   = $clog2(DELAY + 1);
   localparam int unsigned CW   = LEN_W + DW + 1;
   localparam int unsigned MAXL = (32'd1 << LEN_W) - 32'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      CLEAR = 2'd3
   } state_t;

`ifdef BP437SEQ_CLR_EN
   localparam state_t RST_STATE = CLEAR;
   localparam state_t END_STATE = CLEAR;
`else
   localparam state_t RST_STATE = IDLE;
   localparam state_t END_STATE = IDLE;
`endif

   state_t            state;
   logic [CW-1:0]     in_cnt;     // pushes issued this frame, tail included
   logic [LEN_W-1:0]  len;        // captured frame length
   logic [LEN_W-1:0]  out_cnt;    // words emitted this frame
   logic [DW-1:0]     clr_cnt;    // zero pushes issued in CLEAR
   logic              live;       // low for the first cycle out of reset

   logic              adv;
   logic              acc;
   logic              flush_push;
   logic              clr_push;
   logic              capture;
   logic              at_max;
   logic [CW-1:0]     k;

   // Same-cycle handshake: who pushes into the decoder and whether its word is kept
   always_comb begin
      adv        = ~m_valid | m_ready;
      k          = in_cnt + CW'(1);
      at_max     = (k == CW'(MAXL));
      s_ready    = 1'b0;
      flush_push = 1'b0;
      clr_push   = 1'b0;
      if (!rst) begin
         case (state)
            IDLE, RUN: s_ready    = live & adv;
            FLUSH:     flush_push = adv & (in_cnt < (CW'(len) + CW'(DELAY)));
`ifdef BP437SEQ_CLR_EN
            CLEAR:     clr_push   = (clr_cnt < DW'(DELAY));
`endif
            default:   ;
         endcase
      end
      acc     = s_valid & s_ready;
      capture = (acc | flush_push) & (in_cnt >= CW'(DELAY));
      dec_ce  = acc | flush_push | clr_push;
      dec_r   = acc ? s_sym : 4'd0;
   end

   assign busy = (state != IDLE);

   // Frame FSM, counters and registered output word
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RST_STATE;
         in_cnt  <= '0;
         len     <= '0;
         out_cnt <= '0;
         clr_cnt <= '0;
         live    <= 1'b0;
         ovf     <= 1'b0;
         m_data  <= 3'd0;
         m_valid <= 1'b0;
         m_first <= 1'b0;
         m_last  <= 1'b0;
      end else begin
         live <= 1'b1;

         if (capture) begin
            m_data  <= dec_d;
            m_valid <= 1'b1;
            m_first <= (out_cnt == '0);
            m_last  <= (state == FLUSH) && ((out_cnt + LEN_W'(1)) == len);
            out_cnt <= out_cnt + LEN_W'(1);
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (acc) begin
                  in_cnt <= CW'(1);
                  if (s_last) begin
                     len   <= LEN_W'(1);
                     state <= FLUSH;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (acc) begin
                  in_cnt <= k;
                  if (s_last || at_max) begin
                     len   <= LEN_W'(k);
                     state <= FLUSH;
                     if (!s_last) ovf <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (flush_push) in_cnt <= k;
               if (out_cnt == len) begin
                  state   <= END_STATE;
                  in_cnt  <= '0;
                  out_cnt <= '0;
                  clr_cnt <= '0;
               end
            end
`ifdef BP437SEQ_CLR_EN
            CLEAR: begin
               if (clr_push) clr_cnt <= clr_cnt + DW'(1);
               else          state   <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bp437_frame_seq.sv
// Directed bench for bp437_frame_seq. The decoder is modelled as a DELAY-deep
// shift register of received symbols whose output is the data field of the
// symbol DELAY pushes back (parity is ignored, so a parity-bit error is
// always "corrected").

module tb_bp437_frame_seq;

   localparam int unsigned DELAY = 28;
   localparam int unsigned LEN_W = 6;
`ifdef BP437SEQ_CLR_EN
   localparam int TAILS      = 2 * DELAY;
   localparam int BUSY_AFTER = 1;
`else
   localparam int TAILS      = DELAY;
   localparam int BUSY_AFTER = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] s_sym;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic [3:0] dec_r;
   logic       dec_ce;
   logic [2:0] dec_d;
   logic [2:0] m_data;
   logic       m_valid;
   logic       m_first;
   logic       m_last;
   logic       m_ready;
   logic       busy;
   logic       ovf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bp437_frame_seq #(.DELAY(DELAY), .LEN_W(LEN_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_sym   (s_sym),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_ready (s_ready),
      .dec_r   (dec_r),
      .dec_ce  (dec_ce),
      .dec_d   (dec_d),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_first (m_first),
      .m_last  (m_last),
      .m_ready (m_ready),
      .busy    (busy),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // decoder model: data of the symbol pushed DELAY pushes ago
   logic [3:0] sr [DELAY];
   always @(posedge clk) begin
      if (dec_ce) begin
         for (int i = DELAY - 1; i > 0; i--) sr[i] <= sr[i-1];
         sr[0] <= dec_r;
      end
   end
   assign dec_d = sr[DELAY-1][2:0];

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] dat(input int f, input int i);
      int v;
      v = i * 5 + f * 3 + (i >> 2);
      return 3'(v & 7);
   endfunction

   // output monitor
   logic [2:0] rx_d [$];
   logic       rx_f [$];
   logic       rx_l [$];
   int         first_mv_cyc;

   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid && !m_ready) chk("ce_hold", int'(dec_ce), 0);
         if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
         if (m_valid && m_ready) begin
            rx_d.push_back(m_data);
            rx_f.push_back(m_first);
            rx_l.push_back(m_last);
         end
      end
   end

   int acc_cyc;
   int tail;
   int sready_bad;

   // Send n symbols of stream f; stops early once abort_at symbols are accepted
   task automatic run(input int f, input int n, input int use_last, input int bp,
                      input int err_idx, input int abort_at);
      int   sent;
      int   budget;
      bit   done;
      logic a;
      logic [3:0] pat;
      logic [2:0] d;
      pat = 4'b1001;
      sent = 0; budget = 0; done = 0;
      tail = 0; sready_bad = 0; acc_cyc = -1;
      rx_d.delete(); rx_f.delete(); rx_l.delete();
      first_mv_cyc = -1;
      while (!done) begin
         m_ready = bp != 0 ? pat[cyc % 4] : 1'b1;
         s_valid = (sent < n);
         d       = dat(f, sent);
         s_sym   = {(^d) ^ (sent == err_idx), d};
         s_last  = (use_last != 0) && (sent == n - 1);
         @(negedge clk);
         a = s_valid & s_ready;
         if (a && sent == 0) acc_cyc = cyc;
         if (sent == n) begin
            if (dec_ce) tail++;
            if (busy && s_ready) sready_bad++;
         end
         done = (sent == n) && !busy && !m_valid;
         if (a) sent++;
         if (abort_at > 0 && sent == abort_at) done = 1;
         budget++;
         if (budget > 5000) begin
            total++; bad++;
            $display("FAIL timeout got sent=%0d exp=%0d", sent, n);
            done = 1;
         end
         if (done) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end
         @(posedge clk); #1;
      end
      m_ready = 1'b1;
   endtask

   task automatic verify(input string tag, input int f, input int n, input int split);
      int m;
      chk({tag, "_count"}, rx_d.size(), n);
      m = rx_d.size() < n ? rx_d.size() : n;
      for (int i = 0; i < m; i++) begin
         chk({tag, "_data"},  int'(rx_d[i]), int'(dat(f, i)));
         chk({tag, "_first"}, int'(rx_f[i]), int'((i == 0) || (split > 0 && i == split)));
         chk({tag, "_last"},  int'(rx_l[i]), int'((i == n - 1) || (split > 0 && i == split - 1)));
      end
      chk({tag, "_tail"}, tail, TAILS);
      chk({tag, "_sready_flush"}, sready_bad, 0);
      chk({tag, "_busy_end"}, int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_sym = 4'd0; m_ready = 1'b1;
      first_mv_cyc = -1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_dec_ce",  int'(dec_ce), 0);
      chk("rst_dec_r",   int'(dec_r), 0);
      chk("rst_ovf",     int'(ovf), 0);
      chk("rst_busy",    int'(busy), BUSY_AFTER);
      @(posedge clk); #1;

      // error-free L=40, continuous
      run(1, 40, 1, 0, -1, 0);
      verify("l40", 1, 40, 0);
      chk("l40_latency", first_mv_cyc - acc_cyc, DELAY + 1);

      // parity-bit error on symbol 10
      run(2, 40, 1, 0, 9, 0);
      verify("l40err", 2, 40, 0);
      chk("l40err_ovf", int'(ovf), 0);

      // single-symbol frame, then a short frame
      run(3, 1, 1, 0, -1, 0);
      verify("l1", 3, 1, 0);
      chk("l1_latency", first_mv_cyc - acc_cyc, DELAY + 1);
      run(4, 5, 1, 0, -1, 0);
      verify("l5", 4, 5, 0);

      // maximum-length frame under 1,0,0,1 backpressure, s_last at the limit
      run(5, 63, 1, 1, -1, 0);
      verify("l63bp", 5, 63, 0);
      chk("l63bp_ovf", int'(ovf), 0);

      // abandon a frame after 17 symbols
      run(6, 40, 1, 0, -1, 17);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_s_ready", int'(s_ready), 0);
      chk("mid_m_valid", int'(m_valid), 0);
      chk("mid_m_first", int'(m_first), 0);
      chk("mid_m_last",  int'(m_last), 0);
      chk("mid_dec_ce",  int'(dec_ce), 0);
      chk("mid_dec_r",   int'(dec_r), 0);
      chk("mid_busy",    int'(busy), BUSY_AFTER);
      chk("mid_words",   rx_d.size(), 0);
      @(posedge clk); #1;
      run(7, 40, 1, 0, -1, 0);
      verify("after_rst", 7, 40, 0);

      // 70 symbols with s_last only on the final one: split at 63
      run(8, 70, 1, 0, -1, 0);
      verify("ovf70", 8, 70, 63);
      chk("ovf_set", int'(ovf), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
